pe_array_param: RTL and testbench
=================================

// Module: pe_array_param
// PURPOSE
//  Parametrised weight-stationary-skew MAC array: ROWS x (COLS/4) PE_row tiles. Each row gets the
//  shared image vector and a row-skewed copy of the weight vector, and accumulates its own psum.
//  Successor to the fixed 4x4 array: adds generic ROWS/COLS, per-row valid tracking, a broadcast
//  mode, column segmentation with pipeline alignment, and a weight cascade port for tiling arrays.
// PARAMETERS
//  ROWS    4  number of output rows (>=1)
//  COLS    4  input lanes; multiple of 4; SEG = COLS/4 PE_row tiles chained per row
//  PE_LAT  1  cycle latency of one PE_row (psum/img/wgt in -> out)
//  IMG_W=24, WGT_W=36, PSUM_W=16 are localparams fixed by PE_row
// PORTS
//  clk             in   1              clock, rising edge
//  rst             in   1              synchronous active-low reset
//  exp_bias        in   5              exponent bias, forwarded to every PE_row
//  skew_en         in   1              1: row r weights delayed r cycles; 0: broadcast (delay 0)
//  in_valid        in   1              img/wgt lanes valid this cycle
//  img             in   COLS*IMG_W     image lanes, lane c at [c*IMG_W +: IMG_W]
//  wgt             in   COLS*WGT_W     weight lanes, lane c at [c*WGT_W +: WGT_W]
//  psum            in   ROWS*PSUM_W    partial sums, row r at [r*PSUM_W +: PSUM_W]
//  out             out  ROWS*PSUM_W    row results
//  out_valid       out  ROWS           per-row result valid
//  wgt_casc        out  COLS*WGT_W     wgt delayed ROWS cycles (feeds next array's wgt)
//  wgt_casc_valid  out  1              in_valid delayed ROWS cycles
//  busy            out  1              any valid token in flight
// BEHAVIOUR
//  Reset (rst=0 at posedge): all skew/align/valid registers, out_valid, wgt_casc, wgt_casc_valid and
//   busy cleared to 0 the same edge; PE_row tiles get the same rst, so out = 0 until first result.
//  Weight skew chain: wd[0] = wgt; wd[k] = wd[k-1] registered, k = 1..ROWS. Shifts every cycle
//   regardless of in_valid (no data gating). Row r uses wd[r] if skew_en else wd[0].
//   wgt_casc = wd[ROWS] independent of skew_en.
//  Valid chain: vd[k] mirrors wd[k] for in_valid. wgt_casc_valid = vd[ROWS].
//  Segments: row r tile s (0..SEG-1) takes img lanes 4s..4s+3 and the row's weight lanes 4s..4s+3,
//   each delayed s*PE_LAT cycles by alignment registers (shared img delay; per-row wgt delay).
//   Tile 0 psum = psum[r]; tile s psum = out of tile s-1; out[r] = out of tile SEG-1.
//  Row latency L = SEG*PE_LAT. out_valid[r] = in_valid delayed (skew_en ? r : 0) + L cycles,
//   via a per-row shift register of length ROWS-1+L with a tap mux.
//  Caller presents psum[r] in the cycle row r's weights reach tile 0 (in-cycle + r when skewed).
//  busy = OR of all vd[1..ROWS] and per-row valid pipeline bits; a cycle with in_valid=1 sets busy
//   from the next edge; busy drops the cycle after the last out_valid and last wgt_casc_valid.
//  skew_en is quasi-static: change only while busy=0. A change while busy yields undefined out
//   data, but out_valid timing follows the skew_en value sampled at each tap.
//  Back-to-back in_valid supported at full rate; no backpressure and no stall.
//  Reset mid-operation discards all in-flight tokens; no out_valid is produced for them.
//  Arithmetic is entirely inside PE_row; this block adds no arithmetic, only wiring/registers.
// TESTING
//  1 rst=0 for 3 cycles, random inputs, in_valid=1 -> out_valid=0, busy=0, wgt_casc=0,
//    wgt_casc_valid=0 throughout; the first edge with rst=1 still gives out_valid=0.
//  2 ROWS=4,COLS=4,PE_LAT=1,skew_en=1: single in_valid pulse at T, wgt lane0=36'h1 ->
//    row r tile-0 weight = 36'h1 at T+r only; out_valid[r] high at T+r+1 only;
//    wgt_casc lane0=36'h1 and wgt_casc_valid=1 at T+4; busy low from T+6.
//  3 Same with skew_en=0 -> all rows see weight at T, out_valid=4'b1111 at T+1 only.
//  4 COLS=8 (SEG=2), PE_LAT=1, skew_en=1: pulse at T -> tile-1 img/wgt equal to tile-0 inputs
//    one cycle later; out_valid[r] at T+r+2.
//  5 10 consecutive valids from T, ROWS=4,COLS=4 -> out_valid[r] high T+r+1..T+r+10; busy
//    falls T+15.
//  6 Burst from T, rst=0 at edge T+2, then released -> out_valid=0 and busy=0 from T+2 until new
//    valids arrive; a fresh pulse at T+5 gives out_valid[0] at T+6, no stale tokens.

Source files
------------

// File: rtl/pe_array_if.sv
// Bus bundle for pe_array_param: image/weight/psum lanes in, row results,
// weight cascade and status out. The master drives lanes, the slave is the array.
interface pe_array_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int IMG_W  = 24;
    localparam int WGT_W  = 36;
    localparam int PSUM_W = 16;

    logic [4:0]              exp_bias;
    logic                    skew_en;
    logic                    in_valid;
    logic [COLS*IMG_W-1:0]   img;
    logic [COLS*WGT_W-1:0]   wgt;
    logic [ROWS*PSUM_W-1:0]  psum;
    logic [ROWS*PSUM_W-1:0]  out;
    logic [ROWS-1:0]         out_valid;
    logic [COLS*WGT_W-1:0]   wgt_casc;
    logic                    wgt_casc_valid;
    logic                    busy;

    modport master (
        output exp_bias, skew_en, in_valid, img, wgt, psum,
        input  out, out_valid, wgt_casc, wgt_casc_valid, busy
    );

    modport slave (
        input  exp_bias, skew_en, in_valid, img, wgt, psum,
        output out, out_valid, wgt_casc, wgt_casc_valid, busy
    );
endinterface

// File: rtl/pe_array_param.sv
// Parametrised MAC array: ROWS rows, each a chain of COLS/4 pe_row tiles.
// Rows share the image lanes and take a row-skewed (or broadcast) weight copy;
// tiles within a row are aligned by img/wgt delay registers.

// One 4-lane MAC tile: out = sat(psum + (sum img*wgt) >>> exp_bias), LAT cycles.
module pe_row #(
    parameter int LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          exp_bias,
    input  logic [4*24-1:0]     img,
    input  logic [4*36-1:0]     wgt,
    input  logic signed [15:0]  psum,
    output logic signed [15:0]  out
);
    localparam int IMG_W = 24;
    localparam int WGT_W = 36;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)       return 16'sh7FFF;
        else if (v < -64'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    logic signed [63:0] dot;
    logic signed [63:0] acc;
    logic signed [15:0] res;
    logic signed [15:0] acc_p [LAT];

    // Dot product of the four lanes, scaled and added to the incoming psum
    always_comb begin
        dot = '0;
        for (int i = 0; i < 4; i++)
            dot = dot + 64'(signed'(img[i*IMG_W +: IMG_W])) * 64'(signed'(wgt[i*WGT_W +: WGT_W]));
        acc = 64'(psum) + (dot >>> exp_bias);
        res = sat16(acc);
    end

    // Result pipeline, cleared so out reads 0 until the first result
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) acc_p[i] <= '0;
        end else begin
            acc_p[0] <= res;
            for (int i = 1; i < LAT; i++) acc_p[i] <= acc_p[i-1];
        end
    end

    assign out = acc_p[LAT-1];
endmodule

module pe_array_param #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int PE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    pe_array_if.slave   bus
);
    localparam int IMG_W  = 24;
    localparam int WGT_W  = 36;
    localparam int PSUM_W = 16;
    localparam int SEG    = COLS / 4;
    localparam int L      = SEG * PE_LAT;
    localparam int VLEN   = ROWS - 1 + L;
    localparam int ADLY   = (SEG - 1) * PE_LAT;
    localparam int IV     = COLS * IMG_W;
    localparam int WV     = COLS * WGT_W;

    // wd_q[k] holds wgt delayed k+1 cycles; vd_q mirrors it for in_valid
    logic [WV-1:0]          wd_q [ROWS];
    logic [ROWS-1:0]        vd_q;
    logic [ROWS-1:0]        row_busy;
    logic [ROWS-1:0]        ov_w;
    logic [ROWS*PSUM_W-1:0] out_w;
    logic                   busy_q;

    // Weight skew chain, shifts every cycle regardless of in_valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < ROWS; k++) wd_q[k] <= '0;
            vd_q <= '0;
        end else begin
            wd_q[0] <= bus.wgt;
            vd_q[0] <= bus.in_valid;
            for (int k = 1; k < ROWS; k++) begin
                wd_q[k] <= wd_q[k-1];
                vd_q[k] <= vd_q[k-1];
            end
        end
    end

    generate
        if (ADLY > 0) begin : g_img_al
            logic [IV-1:0] img_dq [ADLY];
            // Shared image alignment: img_dq[k] is img delayed k+1 cycles
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < ADLY; k++) img_dq[k] <= '0;
                end else begin
                    img_dq[0] <= bus.img;
                    for (int k = 1; k < ADLY; k++) img_dq[k] <= img_dq[k-1];
                end
            end
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_row
            logic [WV-1:0]             row_wgt;
            logic signed [PSUM_W-1:0]  tile_out [SEG];
            logic [VLEN-1:0]           vsr;

            if (r == 0) begin : g_w0
                assign row_wgt = bus.wgt;
            end else begin : g_wr
                assign row_wgt = bus.skew_en ? wd_q[r-1] : bus.wgt;
            end

            if (ADLY > 0) begin : g_wal
                logic [WV-1:0] wgt_dq [ADLY];
                // Per-row weight alignment for the downstream tiles
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        for (int k = 0; k < ADLY; k++) wgt_dq[k] <= '0;
                    end else begin
                        wgt_dq[0] <= row_wgt;
                        for (int k = 1; k < ADLY; k++) wgt_dq[k] <= wgt_dq[k-1];
                    end
                end
            end

            for (genvar s = 0; s < SEG; s++) begin : g_tile
                logic [4*IMG_W-1:0]        t_img;
                logic [4*WGT_W-1:0]        t_wgt;
                logic signed [PSUM_W-1:0]  t_psum;

                if (s == 0) begin : g_first
                    assign t_img  = bus.img[0 +: 4*IMG_W];
                    assign t_wgt  = row_wgt[0 +: 4*WGT_W];
                    assign t_psum = bus.psum[r*PSUM_W +: PSUM_W];
                end else begin : g_next
                    assign t_img  = g_img_al.img_dq[s*PE_LAT-1][s*4*IMG_W +: 4*IMG_W];
                    assign t_wgt  = g_wal.wgt_dq[s*PE_LAT-1][s*4*WGT_W +: 4*WGT_W];
                    assign t_psum = tile_out[s-1];
                end

                pe_row #(.LAT(PE_LAT)) u_pe (
                    .clk      (clk),
                    .rst      (rst),
                    .exp_bias (bus.exp_bias),
                    .img      (t_img),
                    .wgt      (t_wgt),
                    .psum     (t_psum),
                    .out      (tile_out[s])
                );
            end

            // Per-row valid pipeline; vsr[k] is in_valid delayed k+1 cycles
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vsr <= '0;
                end else begin
                    vsr[0] <= bus.in_valid;
                    for (int k = 1; k < VLEN; k++) vsr[k] <= vsr[k-1];
                end
            end

            assign ov_w[r]                      = bus.skew_en ? vsr[r+L-1] : vsr[L-1];
            assign row_busy[r]                  = |vsr;
            assign out_w[r*PSUM_W +: PSUM_W]    = tile_out[SEG-1];
        end
    endgenerate

    // Busy looks one cycle ahead so it covers the final out_valid/cascade cycle
    always_ff @(posedge clk) begin
        if (!rst) busy_q <= 1'b0;
        else      busy_q <= bus.in_valid | (|vd_q) | (|row_busy);
    end

    assign bus.out            = out_w;
    assign bus.out_valid      = ov_w;
    assign bus.wgt_casc       = wd_q[ROWS-1];
    assign bus.wgt_casc_valid = vd_q[ROWS-1];
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_pe_array_param.sv
// Directed bench for pe_array_param: a 4x4 array and a 4x8 (two-segment) array.
module tb_pe_array_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    pe_array_if #(.ROWS(4), .COLS(4)) b4();
    pe_array_if #(.ROWS(4), .COLS(8)) b8();

    pe_array_param #(.ROWS(4), .COLS(4), .PE_LAT(1)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    pe_array_param #(.ROWS(4), .COLS(8), .PE_LAT(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [3:0][7:0] im;
        logic [3:0][7:0] wg;
        logic [15:0]     ps;
        logic [4:0]      bias;
        logic [15:0]     exp;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [95:0] lanes_img(input logic [3:0][7:0] v);
        logic [95:0] x = '0;
        for (int i = 0; i < 4; i++) x[i*24 +: 24] = {{16{v[i][7]}}, v[i]};
        return x;
    endfunction

    function automatic logic [143:0] lanes_wgt(input logic [3:0][7:0] v);
        logic [143:0] x = '0;
        for (int i = 0; i < 4; i++) x[i*36 +: 36] = {{28{v[i][7]}}, v[i]};
        return x;
    endfunction

    task automatic set_psum4(input int base, input int step);
        for (int r = 0; r < 4; r++) b4.psum[r*16 +: 16] = 16'(base + step*r);
    endtask

    task automatic set_vec(input int n, input logic [3:0][7:0] im, input logic [3:0][7:0] wg,
                           input logic [15:0] ps, input logic [4:0] bias, input logic [15:0] exp);
        tv[n].im = im; tv[n].wg = wg; tv[n].ps = ps; tv[n].bias = bias; tv[n].exp = exp;
    endtask

    // Single pulse on the 4x4 array, skewed or broadcast
    task automatic run_pulse(input logic skew);
        logic [3:0] ev;
        b4.skew_en = skew; b4.exp_bias = 5'd0; b4.in_valid = 1'b0; b4.wgt = '0;
        b4.img = lanes_img({8'd0, 8'd0, 8'd0, 8'd5});
        set_psum4(1, 10);
        repeat (2) cyc();
        for (int k = 0; k < 8; k++) begin
            cyc();
            b4.in_valid = (k == 0);
            b4.wgt = (k == 0) ? lanes_wgt({8'd0, 8'd0, 8'd0, 8'd1}) : '0;
            smp();
            for (int r = 0; r < 4; r++) ev[r] = skew ? (k == r + 1) : (k == 1);
            chk($sformatf("pulse%0d_ov_k%0d", skew, k), 160'(b4.out_valid), 160'(ev));
            for (int r = 0; r < 4; r++)
                chk($sformatf("pulse%0d_out_k%0d_r%0d", skew, k, r), 160'(b4.out[r*16 +: 16]),
                    160'(10*r + 1 + (ev[r] ? 5 : 0)));
            chk($sformatf("pulse%0d_casc_k%0d", skew, k), 160'(b4.wgt_casc), 160'((k == 4) ? 1 : 0));
            chk($sformatf("pulse%0d_cascv_k%0d", skew, k), 160'(b4.wgt_casc_valid), 160'(k == 4));
            chk($sformatf("pulse%0d_busy_k%0d", skew, k), 160'(b4.busy), 160'(k >= 1 && k <= 5));
        end
        repeat (4) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ev;
        logic [191:0] img8;
        logic [287:0] wgt8;

        set_vec(0, {8'd0, 8'd0, 8'd0, 8'd5},         {8'd0, 8'd0, 8'd0, 8'd1},          16'd100,    5'd0, 16'h0069);
        set_vec(1, {8'd0, 8'd0, 8'd0, 8'hFD},        {8'd0, 8'd0, 8'd0, 8'd7},          16'd10,     5'd0, 16'hFFF5);
        set_vec(2, {8'd0, 8'd0, 8'd0, 8'd100},       {8'd0, 8'd0, 8'd0, 8'd100},        16'd30000,  5'd0, 16'h7FFF);
        set_vec(3, {8'd0, 8'd0, 8'd0, 8'h80},        {8'd0, 8'd0, 8'd0, 8'd127},        16'h8AD0,   5'd0, 16'h8000);
        set_vec(4, {8'd0, 8'd0, 8'd0, 8'd16},        {8'd0, 8'd0, 8'd0, 8'd16},         16'd0,      5'd4, 16'h0010);
        set_vec(5, {8'd4, 8'd3, 8'd2, 8'd1},         {8'd1, 8'd2, 8'd3, 8'd4},          16'd5,      5'd0, 16'h0019);
        set_vec(6, {8'd0, 8'd0, 8'd0, 8'hFB},        {8'd0, 8'd0, 8'd0, 8'd1},          16'd0,      5'd1, 16'hFFFD);
        set_vec(7, {8'd0, 8'd0, 8'd0, 8'd50},        {8'd0, 8'd0, 8'd0, 8'hEC},         16'd1000,   5'd2, 16'h02EE);

        b4.exp_bias = '0; b4.skew_en = 1'b1; b4.in_valid = 1'b0; b4.img = '0; b4.wgt = '0; b4.psum = '0;
        b8.exp_bias = '0; b8.skew_en = 1'b1; b8.in_valid = 1'b0; b8.img = '0; b8.wgt = '0; b8.psum = '0;

        // Reset with random traffic and in_valid high
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            b4.in_valid = 1'b1; b8.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                b4.img[i*24 +: 24] = 24'($urandom);
                b4.wgt[i*36 +: 32] = $urandom;
            end
            for (int i = 0; i < 8; i++) begin
                b8.img[i*24 +: 24] = 24'($urandom);
                b8.wgt[i*36 +: 32] = $urandom;
            end
            b4.psum = 64'({$urandom, $urandom});
            smp();
            chk($sformatf("rst_ov_k%0d", k), 160'(b4.out_valid), 160'(0));
            chk($sformatf("rst_busy_k%0d", k), 160'(b4.busy), 160'(0));
            chk($sformatf("rst_casc_k%0d", k), 160'(b4.wgt_casc), 160'(0));
            chk($sformatf("rst_cascv_k%0d", k), 160'(b4.wgt_casc_valid), 160'(0));
            chk($sformatf("rst_out_k%0d", k), 160'(b4.out), 160'(0));
            chk($sformatf("rst_ov8_k%0d", k), 160'(b8.out_valid), 160'(0));
        end
        cyc();
        rst = 1'b1; b4.in_valid = 1'b0; b8.in_valid = 1'b0; b4.wgt = '0; b8.wgt = '0;
        cyc();
        smp();
        chk("rel_ov", 160'(b4.out_valid), 160'(0));
        chk("rel_busy", 160'(b4.busy), 160'(0));
        chk("rel_ov8", 160'(b8.out_valid), 160'(0));
        b8.img = '0; b8.psum = '0;
        repeat (3) cyc();

        // Broadcast vectors: every row sees the same weights one cycle later
        for (int n = 0; n < 8; n++) begin
            cyc();
            b4.skew_en = 1'b0; b4.exp_bias = tv[n].bias;
            b4.img = lanes_img(tv[n].im); b4.wgt = lanes_wgt(tv[n].wg);
            for (int r = 0; r < 4; r++) b4.psum[r*16 +: 16] = tv[n].ps;
            b4.in_valid = 1'b1;
            cyc();
            b4.in_valid = 1'b0; b4.wgt = '0;
            smp();
            chk($sformatf("vec%0d_ov", n), 160'(b4.out_valid), 160'(4'hF));
            for (int r = 0; r < 4; r++)
                chk($sformatf("vec%0d_out_r%0d", n, r), 160'(b4.out[r*16 +: 16]), 160'(tv[n].exp));
        end
        repeat (8) cyc();

        run_pulse(1'b1);
        run_pulse(1'b0);

        // Two-segment array: tile 1 must use the image/weight from one cycle earlier
        b8.skew_en = 1'b1; b8.exp_bias = 5'd0; b8.in_valid = 1'b0; b8.wgt = '0;
        for (int r = 0; r < 4; r++) b8.psum[r*16 +: 16] = 16'(r);
        for (int k = -2; k < 9; k++) begin
            cyc();
            img8 = '0;
            img8[0 +: 24]    = 24'd3;
            img8[4*24 +: 24] = 24'(10 + k);
            b8.img = img8;
            if (k >= 0) begin
                wgt8 = '0;
                if (k == 0) begin
                    wgt8[0 +: 36]    = 36'd1;
                    wgt8[4*36 +: 36] = 36'd2;
                end
                b8.wgt = wgt8;
                b8.in_valid = (k == 0);
                smp();
                for (int r = 0; r < 4; r++) ev[r] = (k == r + 2);
                chk($sformatf("seg_ov_k%0d", k), 160'(b8.out_valid), 160'(ev));
                for (int r = 0; r < 4; r++)
                    chk($sformatf("seg_out_k%0d_r%0d", k, r), 160'(b8.out[r*16 +: 16]),
                        160'(ev[r] ? (r + 3 + 2*(10 + r)) : r));
                chk($sformatf("seg_busy_k%0d", k), 160'(b8.busy), 160'(k >= 1 && k <= 6));
            end
        end
        b8.in_valid = 1'b0;
        repeat (6) cyc();

        // Ten back-to-back valids, image lane 0 = k+1 each cycle
        b4.skew_en = 1'b1; b4.exp_bias = 5'd0; b4.in_valid = 1'b0; b4.wgt = '0;
        set_psum4(1, 10);
        repeat (2) cyc();
        for (int k = 0; k < 17; k++) begin
            cyc();
            b4.in_valid = (k < 10);
            b4.wgt = (k < 10) ? lanes_wgt({8'd0, 8'd0, 8'd0, 8'd1}) : '0;
            b4.img = lanes_img({8'd0, 8'd0, 8'd0, 8'(k + 1)});
            smp();
            for (int r = 0; r < 4; r++) ev[r] = (k >= r + 1) && (k <= r + 10);
            chk($sformatf("burst_ov_k%0d", k), 160'(b4.out_valid), 160'(ev));
            for (int r = 0; r < 4; r++)
                if (ev[r])
                    chk($sformatf("burst_out_k%0d_r%0d", k, r), 160'(b4.out[r*16 +: 16]), 160'(10*r + 1 + k));
            chk($sformatf("burst_busy_k%0d", k), 160'(b4.busy), 160'(k >= 1 && k <= 14));
        end
        repeat (4) cyc();

        // Reset in the middle of a burst, then a fresh pulse at k=5
        b4.img = lanes_img({8'd0, 8'd0, 8'd0, 8'd5});
        set_psum4(1, 10);
        repeat (2) cyc();
        for (int k = 0; k < 12; k++) begin
            cyc();
            rst = (k != 1);
            b4.in_valid = (k <= 1) || (k == 5);
            b4.wgt = b4.in_valid ? lanes_wgt({8'd0, 8'd0, 8'd0, 8'd1}) : '0;
            smp();
            if (k == 2) begin
                chk("mrst_out", 160'(b4.out), 160'(0));
                chk("mrst_casc", 160'(b4.wgt_casc), 160'(0));
            end
            if (k >= 2 && k <= 5) begin
                chk($sformatf("mrst_ov_k%0d", k), 160'(b4.out_valid), 160'(0));
                chk($sformatf("mrst_busy_k%0d", k), 160'(b4.busy), 160'(0));
            end
            if (k >= 6 && k <= 9)
                chk($sformatf("mrst_ov_k%0d", k), 160'(b4.out_valid), 160'(4'b0001 << (k - 6)));
            if (k == 6) begin
                chk("mrst_out0", 160'(b4.out[15:0]), 160'(6));
                chk("mrst_busy6", 160'(b4.busy), 160'(1));
            end
            if (k == 11) chk("mrst_busy11", 160'(b4.busy), 160'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
